// File: rtl/fdivsqrt_seq_ctrl.sv
// Sequencing controller for the shared divide/square-root iteration datapath.
// Counts the requested iteration steps, then holds the result until Memory accepts it.
module fdivsqrt_seq_ctrl #(
    parameter int DURLEN = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              DivStartE,
    input  logic [DURLEN-1:0] CyclesE,
    input  logic              SpecialCaseE,
    input  logic              StallM,
    input  logic              FlushE,
    output logic              IFDivStartE,
    output logic              IterateE,
    output logic              FDivBusyE,
    output logic              FDivDoneE,
    output logic [DURLEN-1:0] StepE
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [DURLEN-1:0] STEP_ZERO = '0;
    localparam logic [DURLEN-1:0] STEP_ONE  = {{(DURLEN-1){1'b0}}, 1'b1};

    state_t            state_q, state_d;
    logic [DURLEN-1:0] step_q, step_d;
    logic              start;
    logic              in_idle, in_busy, in_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            step_q  <= STEP_ZERO;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    // Outputs are forced low while reset is held, even though the registers
    // only clear on the following edge.
    always_comb begin
        in_idle     = (state_q == IDLE);
        in_busy     = (state_q == BUSY) & ~reset;
        in_done     = (state_q == DONE) & ~reset;
        start       = DivStartE & in_idle & ~FlushE & ~reset;
        IFDivStartE = start;
        IterateE    = in_busy;
        FDivDoneE   = in_done;
        FDivBusyE   = start | in_busy;
        StepE       = reset ? STEP_ZERO : step_q;
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (FlushE) begin
            state_d = IDLE;
            step_d  = STEP_ZERO;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        if (SpecialCaseE) begin
                            state_d = DONE;
                            step_d  = STEP_ZERO;
                        end else begin
                            state_d = BUSY;
                            // A zero count still performs one step so the counter never wraps.
                            step_d  = (CyclesE == STEP_ZERO) ? STEP_ONE : CyclesE;
                        end
                    end
                end
                BUSY: begin
                    if (step_q > STEP_ONE) begin
                        step_d = step_q - STEP_ONE;
                    end else begin
                        state_d = DONE;
                        step_d  = STEP_ZERO;
                    end
                end
                DONE: begin
                    if (!StallM) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    step_d  = STEP_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fdivsqrt_seq_ctrl.sv
// Bench for fdivsqrt_seq_ctrl: directed vector table, long-count and reset sequences,
// then randomized traffic against a timeline-based reference model.
module tb_fdivsqrt_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       DivStartE = 1'b0;
    logic [5:0] CyclesE = '0;
    logic       SpecialCaseE = 1'b0;
    logic       StallM = 1'b0;
    logic       FlushE = 1'b0;
    logic       IFDivStartE, IterateE, FDivBusyE, FDivDoneE;
    logic [5:0] StepE;

    int n_vec = 0;
    int n_bad = 0;

    fdivsqrt_seq_ctrl #(.DURLEN(6)) dut (
        .clk(clk), .reset(reset), .DivStartE(DivStartE), .CyclesE(CyclesE),
        .SpecialCaseE(SpecialCaseE), .StallM(StallM), .FlushE(FlushE),
        .IFDivStartE(IFDivStartE), .IterateE(IterateE), .FDivBusyE(FDivBusyE),
        .FDivDoneE(FDivDoneE), .StepE(StepE)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, ds;
        logic [5:0] c;
        logic       sp, st, fl;
        logic [9:0] exp;   // {IFDivStartE, IterateE, FDivBusyE, FDivDoneE, StepE}
    } vec_t;

    vec_t vecs[$];

    function automatic void add_v(input logic r, ds, input logic [5:0] c, input logic sp, st, fl,
                                  input logic ifs, it, bz, dn, input logic [5:0] s);
        vec_t v;
        v.r = r; v.ds = ds; v.c = c; v.sp = sp; v.st = st; v.fl = fl;
        v.exp = {ifs, it, bz, dn, s};
        vecs.push_back(v);
    endfunction

    // Reference model: an accepted op is remembered by its start cycle and length;
    // iteration and completion windows follow from cycle arithmetic.
    int   cyc = 0;
    bit   m_act = 0;
    bit   m_sp = 0;
    int   m_t = 0, m_n = 0, m_done = 0;

    function automatic logic [9:0] model_out();
        logic ifs, it, dn;
        int   s;
        if (reset) return 10'd0;
        it  = m_act && !m_sp && (cyc > m_t) && (cyc <= m_t + m_n);
        dn  = m_act && (cyc >= m_done);
        s   = it ? (m_t + m_n - cyc + 1) : 0;
        ifs = DivStartE && !m_act && !FlushE;
        return {ifs, it, ifs | it, dn, 6'(s)};
    endfunction

    function automatic void model_step();
        logic [9:0] o;
        o = model_out();
        if (reset || FlushE) begin
            m_act = 0;
        end else if (o[9]) begin
            m_act  = 1;
            m_t    = cyc;
            m_sp   = SpecialCaseE;
            m_n    = (CyclesE == 0) ? 1 : int'(CyclesE);
            m_done = m_t + (m_sp ? 1 : m_n + 1);
        end else if (o[6] && !StallM) begin
            m_act = 0;
        end
    endfunction

    task automatic drive(input logic r, ds, input logic [5:0] c, input logic sp, st, fl);
        reset = r; DivStartE = ds; CyclesE = c; SpecialCaseE = sp; StallM = st; FlushE = fl;
        #2;
    endtask

    task automatic check(input string nm, input logic [9:0] exp);
        logic [9:0] got;
        got = {IFDivStartE, IterateE, FDivBusyE, FDivDoneE, StepE};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got ifs/it/busy/done/step=%b/%b/%b/%b/%0d want %b/%b/%b/%b/%0d",
                     nm, cyc, got[9], got[8], got[7], got[6], got[5:0],
                     exp[9], exp[8], exp[7], exp[6], exp[5:0]);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        // reset, even with a start request present
        add_v(1,1,5,0,0,0, 0,0,0,0,0);
        add_v(1,1,5,0,0,0, 0,0,0,0,0);
        // CyclesE=5 plain op
        add_v(0,1,5,0,0,0, 1,0,1,0,0);
        add_v(0,0,0,0,0,0, 0,1,1,0,5);
        add_v(0,0,0,0,0,0, 0,1,1,0,4);
        add_v(0,0,0,0,0,0, 0,1,1,0,3);
        add_v(0,0,0,0,0,0, 0,1,1,0,2);
        add_v(0,0,0,0,0,0, 0,1,1,0,1);
        add_v(0,0,0,0,0,0, 0,0,0,1,0);
        add_v(0,0,0,0,0,0, 0,0,0,0,0);
        // special case: done next cycle, no iteration
        add_v(0,1,20,1,0,0, 1,0,1,0,0);
        add_v(0,0,0,0,0,0, 0,0,0,1,0);
        add_v(0,0,0,0,0,0, 0,0,0,0,0);
        // DONE held by StallM for 3 cycles, start during hold ignored
        add_v(0,1,1,0,0,0, 1,0,1,0,0);
        add_v(0,0,0,0,0,0, 0,1,1,0,1);
        add_v(0,0,0,0,1,0, 0,0,0,1,0);
        add_v(0,1,7,0,1,0, 0,0,0,1,0);
        add_v(0,0,0,0,1,0, 0,0,0,1,0);
        add_v(0,0,0,0,0,0, 0,0,0,1,0);
        add_v(0,0,0,0,0,0, 0,0,0,0,0);
        // flush with StepE=2, then flush+start in IDLE
        add_v(0,1,3,0,0,0, 1,0,1,0,0);
        add_v(0,0,0,0,0,0, 0,1,1,0,3);
        add_v(0,0,0,0,0,1, 0,1,1,0,2);
        add_v(0,0,0,0,0,0, 0,0,0,0,0);
        add_v(0,0,0,0,0,0, 0,0,0,0,0);
        add_v(0,1,4,0,0,1, 0,0,0,0,0);
        add_v(0,0,0,0,0,0, 0,0,0,0,0);
        // CyclesE=0 runs exactly one step
        add_v(0,1,0,0,0,0, 1,0,1,0,0);
        add_v(0,0,0,0,0,0, 0,1,1,0,1);
        add_v(0,0,0,0,0,0, 0,0,0,1,0);
        add_v(0,0,0,0,0,0, 0,0,0,0,0);
        // flush while DONE is stalled drops the result
        add_v(0,1,0,1,1,0, 1,0,1,0,0);
        add_v(0,0,0,0,1,1, 0,0,0,1,0);
        add_v(0,0,0,0,1,0, 0,0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].ds, vecs[i].c, vecs[i].sp, vecs[i].st, vecs[i].fl);
            check($sformatf("vec%0d", i), vecs[i].exp);
            tick();
        end

        // CyclesE=63: 63 iteration cycles counting down, done at t+64
        drive(0,1,63,0,0,0);
        check("c63_start", {1'b1,1'b0,1'b1,1'b0,6'd0});
        tick();
        for (int i = 0; i < 63; i++) begin
            drive(0,0,0,0,0,0);
            check($sformatf("c63_iter%0d", i), {1'b0,1'b1,1'b1,1'b0,6'(63 - i)});
            tick();
        end
        drive(0,0,0,0,0,0);
        check("c63_done", {1'b0,1'b0,1'b0,1'b1,6'd0});
        tick();
        check("c63_idle", 10'd0);
        tick();

        // reset mid-operation gates outputs, no partial done afterwards
        drive(0,1,4,0,0,0);
        check("rst_mid_start", {1'b1,1'b0,1'b1,1'b0,6'd0});
        tick();
        drive(0,0,0,0,0,0);
        check("rst_mid_iter", {1'b0,1'b1,1'b1,1'b0,6'd4});
        tick();
        drive(1,1,4,0,0,0);
        check("rst_mid_gated", 10'd0);
        tick();
        drive(0,0,0,0,0,0);
        check("rst_mid_after", 10'd0);
        tick();
        check("rst_mid_after2", 10'd0);
        tick();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic [5:0] c;
            c = ($urandom_range(0, 15) == 0) ? 6'd63 : 6'($urandom_range(0, 9));
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0), c,
                  ($urandom_range(0, 4) == 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 15) == 0));
            check("rand", model_out());
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
